// File: rtl/sample_fifo_reader_if.sv
// Port bundle for the sample FIFO reader: shifter write side, read-slot grant,
// codec handshake and buffer status, plus the FSM state for observation.
interface sample_fifo_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  enable_read;
    // audio_valid rises with a new audio_data and both stay frozen until the
    // codec raises audio_ready; the transfer completes on the edge where
    // valid && ready, and valid never drops without that transfer.
    logic                  audio_ready;
    logic [DATA_WIDTH-1:0] audio_data;
    logic                  audio_valid;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   fill_level;
    logic                  overflow;
    logic [7:0]            underrun_count;
    logic                  fsm_state;

    modport master (
        output wr_en, wr_data, enable_read, audio_ready,
        input  audio_data, audio_valid, full, empty, fill_level,
               overflow, underrun_count, fsm_state
    );

    modport slave (
        input  wr_en, wr_data, enable_read, audio_ready,
        output audio_data, audio_valid, full, empty, fill_level,
               overflow, underrun_count, fsm_state
    );
endinterface

// File: rtl/sample_fifo_reader.sv
// Ring buffer between the sample shifter and the audio codec: one pop per
// audio-rate tick, only inside granted read slots, with underrun/overflow status.
module sample_fifo_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int TICK_DIV   = 1042
) (
    input  logic                clk,
    input  logic                reset,
    sample_fifo_reader_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]    TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [DEPTH_LOG2:0] FILL_MAX  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        S_WAIT    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   fill_q, fill_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pending_q, pending_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            underrun_q, underrun_d;

    logic full, empty, tick, serve, push, pop;

    // Status comes from the registered occupancy, so every decision below sees pre-edge values.
    assign full  = (fill_q == FILL_MAX);
    assign empty = (fill_q == '0);
    assign tick  = (cnt_q == TICK_LAST);
    assign serve = (state_q == S_WAIT) && pending_q && bus.enable_read;
    assign push  = bus.wr_en && !full;
    assign pop   = serve && !empty;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        data_d     = data_q;
        valid_d    = valid_q;
        overflow_d = overflow_q | (bus.wr_en & full);
        underrun_d = underrun_q;
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        // A tick landing on an already pending one is lost; a fresh tick wins over a clear.
        pending_d  = tick | (pending_q & ~serve);

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase

        case (state_q)
            S_WAIT: begin
                if (serve) begin
                    if (empty) begin
                        data_d = '0;
                        if (underrun_q != 8'hFF) underrun_d = underrun_q + 8'd1;
                    end else begin
                        data_d = mem[rd_ptr_q];
                    end
                    valid_d = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (valid_q && bus.audio_ready) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_WAIT;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.audio_data     = data_q;
    assign bus.audio_valid    = valid_q;
    assign bus.full           = full;
    assign bus.empty          = empty;
    assign bus.fill_level     = fill_q;
    assign bus.overflow       = overflow_q;
    assign bus.underrun_count = underrun_q;
    assign bus.fsm_state      = state_q;
endmodule

// File: tb/tb_sample_fifo_reader.sv
// Bench for sample_fifo_reader: directed scenarios plus random traffic, checked by a
// queue-based reference model and an output monitor.
module tb_sample_fifo_reader;
    localparam int DW    = 16;
    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;
    localparam int TD    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sample_fifo_reader_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) bus ();

    sample_fifo_reader #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: samples held in a queue, ticks derived from the cycle count.
    logic [DW-1:0] m_buf[$];
    logic [DW-1:0] exp_q[$];
    int            m_cnt;
    bit            m_pend, m_present, m_ovf;
    int            m_unr;
    bit            was_full, was_empty, served;
    logic [DW-1:0] sample;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_buf.delete();
            exp_q.delete();
            m_cnt = 0; m_pend = 0; m_present = 0; m_ovf = 0; m_unr = 0;
        end else begin
            was_full  = (m_buf.size() == DEPTH);
            was_empty = (m_buf.size() == 0);
            served    = !m_present && m_pend && bus.enable_read;
            if (m_present && bus.audio_ready) m_present = 0;
            if (served) begin
                if (was_empty) begin
                    sample = '0;
                    if (m_unr < 255) m_unr++;
                end else begin
                    sample = m_buf.pop_front();
                end
                exp_q.push_back(sample);
                m_present = 1;
            end
            if (bus.wr_en) begin
                if (was_full) m_ovf = 1;
                else m_buf.push_back(bus.wr_data);
            end
            if (m_cnt == TD - 1) m_pend = 1;
            else if (served) m_pend = 0;
            m_cnt = (m_cnt + 1) % TD;
        end
    end

    // Monitor: compares outputs against the model mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid", bus.audio_valid, m_present);
            check("state", bus.fsm_state, m_present);
            check("fill", bus.fill_level, m_buf.size());
            check("full", bus.full, m_buf.size() == DEPTH);
            check("empty", bus.empty, m_buf.size() == 0);
            check("overflow", bus.overflow, m_ovf);
            check("underrun", bus.underrun_count, m_unr);
            if (bus.audio_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL data: valid with data %0h but nothing expected", bus.audio_data);
                end else begin
                    check("data", bus.audio_data, exp_q[0]);
                    if (bus.audio_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic wr, input logic [DW-1:0] d, input logic en, input logic rdy);
        bus.wr_en       = wr;
        bus.wr_data     = d;
        bus.enable_read = en;
        bus.audio_ready = rdy;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0);
        #1;
        check("rst_valid", bus.audio_valid, 1'b0);
        check("rst_data", bus.audio_data, 16'h0);
        check("rst_empty", bus.empty, 1'b1);
        check("rst_full", bus.full, 1'b0);
        check("rst_fill", bus.fill_level, 0);
        check("rst_ovf", bus.overflow, 1'b0);
        check("rst_unr", bus.underrun_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_model_cnt(input int target, input string name);
        int guard = 0;
        while (m_cnt != target && guard < 2 * TD) begin
            step(1);
            guard++;
        end
        check(name, m_cnt, target);
    endtask

    logic [DW-1:0] s0;
    int            guard;
    int            wr_thr;

    initial begin
        rst = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0);

        // Idle: three silent ticks.
        do_reset();
        bus.audio_ready = 1'b1;
        for (int i = 0; i < 3 * TD + 4; i++) begin
            bus.enable_read = i[0];
            step(1);
        end
        bus.enable_read = 1'b0;
        check("t1_unr", bus.underrun_count, 3);
        check("t1_empty", bus.empty, 1'b1);
        check("t1_ovf", bus.overflow, 1'b0);

        // Three samples served in order.
        do_reset();
        for (int i = 0; i < 4 * TD; i++) begin
            set_in(i < 3, DW'(16'h0011 * (i + 1)), i[0], 1'b1);
            step(1);
        end
        bus.enable_read = 1'b0;
        check("t2_unr", bus.underrun_count, 0);
        check("t2_fill", bus.fill_level, 0);

        // Fill to full, drop the 17th write, then drain.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_in(1'b1, DW'(i), 1'b0, 1'b1);
            step(1);
            if (i == 15) begin
                check("t3_full16", bus.full, 1'b1);
                check("t3_noovf16", bus.overflow, 1'b0);
            end
        end
        set_in(1'b0, '0, 1'b0, 1'b1);
        check("t3_full", bus.full, 1'b1);
        check("t3_ovf", bus.overflow, 1'b1);
        check("t3_fill", bus.fill_level, 16);
        bus.enable_read = 1'b1;
        step(17 * TD);
        bus.enable_read = 1'b0;
        step(2);
        check("t3_drained", bus.fill_level, 0);

        // Codec stall: extra ticks collapse into one pending pop.
        do_reset();
        s0 = DW'($urandom_range(1, 16'hFFFF));
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, (i == 0) ? s0 : DW'($urandom), 1'b1, 1'b0);
            step(1);
        end
        bus.wr_en = 1'b0;
        step(5 * TD);
        check("t4_held_valid", bus.audio_valid, 1'b1);
        check("t4_held_data", bus.audio_data, s0);
        wait_model_cnt(1, "t4_align");
        bus.audio_ready = 1'b1;
        step(2);
        bus.enable_read = 1'b0;
        step(2);
        check("t4_fill", bus.fill_level, 2);

        // Tick during a closed read slot is served on the first open slot.
        do_reset();
        set_in(1'b1, 16'hBEEF, 1'b0, 1'b1);
        step(1);
        bus.wr_en = 1'b0;
        wait_model_cnt(TD - 1, "t5_align");
        step(3);
        check("t5_no_valid", bus.audio_valid, 1'b0);
        bus.enable_read = 1'b1;
        step(1);
        bus.enable_read = 1'b0;
        check("t5_valid", bus.audio_valid, 1'b1);
        check("t5_fill", bus.fill_level, 0);
        step(2);

        // Asynchronous reset while presenting.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, DW'($urandom), 1'b0, 1'b0);
            step(1);
        end
        set_in(1'b0, '0, 1'b1, 1'b0);
        guard = 0;
        while (!bus.audio_valid && guard < 3 * TD) begin
            step(1);
            guard++;
        end
        check("t6_presenting", bus.audio_valid, 1'b1);
        check("t6_fill8", bus.fill_level, 8);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_valid", bus.audio_valid, 1'b0);
        check("t6_async_fill", bus.fill_level, 0);
        check("t6_async_empty", bus.empty, 1'b1);
        set_in(1'b0, '0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(TD + 3);
        check("t6_unr", bus.underrun_count, 1);

        // Random traffic at several write rates.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            wr_thr = (p == 0) ? 1 : (p == 1) ? 3 : 8;
            for (int i = 0; i < 800; i++) begin
                set_in($urandom_range(0, 15) < wr_thr, DW'($urandom),
                       $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
                step(1);
            end
        end
        set_in(1'b0, '0, 1'b0, 1'b1);
        step(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
